// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared parser states, running-status kinds and MIDI byte constants
package midi_pkg;

   typedef enum logic [1:0] {
      WAIT_STATUS,
      WAIT_D1,
      WAIT_D2,
      ALLOC
   } parse_state_t;

   // RS_IGNORE keeps data bytes framed for channel messages this block does not act on
   typedef enum logic [1:0] {
      RS_NONE,
      RS_IGNORE,
      RS_NOTE_OFF,
      RS_NOTE_ON
   } run_status_t;

   localparam logic [3:0] NOTE_OFF      = 4'h8;
   localparam logic [3:0] NOTE_ON       = 4'h9;
   localparam logic [7:0] REALTIME_MIN  = 8'hF8;
   localparam logic [7:0] SYSCOMMON_MIN = 8'hF0;

endpackage

// File: rtl/midi_voice_select.sv
// rtl/midi_voice_select.sv - combinational search for matching, free and oldest voices
module midi_voice_select
   import midi_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int IW         = $clog2(NUM_VOICES)
) (
   input  logic [NUM_VOICES-1:0]    gates,
   input  logic [7*NUM_VOICES-1:0]  notes,
   input  logic [IW*NUM_VOICES-1:0] ages,
   input  logic [6:0]               note,
   output logic                     match_hit,
   output logic [IW-1:0]            match_idx,
   output logic                     free_hit,
   output logic [IW-1:0]            free_idx,
   output logic [IW-1:0]            oldest_idx
);

   logic          found;
   logic [IW-1:0] best;

   always_comb begin
      match_hit  = 1'b0;
      match_idx  = '0;
      free_hit   = 1'b0;
      free_idx   = '0;
      oldest_idx = '0;
      found      = 1'b0;
      best       = '0;
      // Descending scan so the lowest index is the last writer
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (gates[i] && notes[7*i +: 7] == note) begin
            match_hit = 1'b1;
            match_idx = IW'(i);
         end
         if (!gates[i]) begin
            free_hit = 1'b1;
            free_idx = IW'(i);
         end
      end
      // Strict compare keeps the lowest index among equally old voices
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (gates[i] && (!found || ages[IW*i +: IW] > best)) begin
            found      = 1'b1;
            best       = ages[IW*i +: IW];
            oldest_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/midi_voice_allocator.sv
// rtl/midi_voice_allocator.sv - MIDI Note On/Off parser and voice allocator; MIDI_VOICE_STEAL_EN enables stealing
module midi_voice_allocator
   import midi_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int CHANNEL    = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   output logic                    byte_rd,
   output logic [NUM_VOICES-1:0]   voice_gate,
   output logic [7*NUM_VOICES-1:0] voice_note,
   output logic [7*NUM_VOICES-1:0] voice_vel,
   output logic                    alloc_drop
);

   localparam int            IW      = $clog2(NUM_VOICES);
   localparam logic [IW-1:0] AGE_MAX = IW'(NUM_VOICES - 1);
`ifdef MIDI_VOICE_STEAL_EN
   localparam bit STEAL_EN = 1'b1;
`else
   localparam bit STEAL_EN = 1'b0;
`endif

   parse_state_t             state, state_nxt;
   run_status_t              rs, rs_nxt;
   logic [6:0]               data1, data1_nxt, data2, data2_nxt;
   logic [IW*NUM_VOICES-1:0] ages;
   logic                     match_hit, free_hit, tgt_hit, note_on;
   logic [IW-1:0]            match_idx, free_idx, oldest_idx, tgt_idx;

   assign byte_rd = reset && byte_valid && (state != ALLOC);
   assign note_on = (rs == RS_NOTE_ON) && (data2 != 7'd0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= WAIT_STATUS;
         rs    <= RS_NONE;
         data1 <= '0;
         data2 <= '0;
      end else begin
         state <= state_nxt;
         rs    <= rs_nxt;
         data1 <= data1_nxt;
         data2 <= data2_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rs_nxt    = rs;
      data1_nxt = data1;
      data2_nxt = data2;
      if (state == ALLOC) begin
         state_nxt = WAIT_STATUS;
      end else if (byte_rd && byte_in < REALTIME_MIN) begin
         if (byte_in >= SYSCOMMON_MIN) begin
            rs_nxt    = RS_NONE;
            state_nxt = WAIT_STATUS;
         end else if (byte_in[7]) begin
            if (byte_in[3:0] == 4'(CHANNEL) && byte_in[7:4] == NOTE_ON)
               rs_nxt = RS_NOTE_ON;
            else if (byte_in[3:0] == 4'(CHANNEL) && byte_in[7:4] == NOTE_OFF)
               rs_nxt = RS_NOTE_OFF;
            else
               rs_nxt = RS_IGNORE;
            state_nxt = WAIT_D1;
         end else begin
            case (state)
               WAIT_STATUS: begin
                  if (rs != RS_NONE) begin
                     data1_nxt = byte_in[6:0];
                     state_nxt = WAIT_D2;
                  end
               end
               WAIT_D1: begin
                  data1_nxt = byte_in[6:0];
                  state_nxt = WAIT_D2;
               end
               WAIT_D2: begin
                  data2_nxt = byte_in[6:0];
                  state_nxt = (rs == RS_NOTE_ON || rs == RS_NOTE_OFF) ? ALLOC : WAIT_STATUS;
               end
               default: state_nxt = WAIT_STATUS;
            endcase
         end
      end
   end

   midi_voice_select #(.NUM_VOICES(NUM_VOICES), .IW(IW)) u_select (
      .gates      (voice_gate),
      .notes      (voice_note),
      .ages       (ages),
      .note       (data1),
      .match_hit  (match_hit),
      .match_idx  (match_idx),
      .free_hit   (free_hit),
      .free_idx   (free_idx),
      .oldest_idx (oldest_idx)
   );

   always_comb begin
      tgt_hit = match_hit || free_hit;
      tgt_idx = match_hit ? match_idx : free_idx;
      if (!tgt_hit && STEAL_EN) begin
         tgt_hit = 1'b1;
         tgt_idx = oldest_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         voice_gate <= '0;
         voice_note <= '0;
         voice_vel  <= '0;
         ages       <= '0;
         alloc_drop <= 1'b0;
      end else begin
         alloc_drop <= 1'b0;
         if (state == ALLOC) begin
            if (note_on) begin
               if (tgt_hit) begin
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     if (IW'(i) == tgt_idx) begin
                        voice_gate[i]       <= 1'b1;
                        voice_note[7*i +: 7] <= data1;
                        voice_vel[7*i +: 7]  <= data2;
                        ages[IW*i +: IW]     <= '0;
                     end else if (voice_gate[i] && ages[IW*i +: IW] != AGE_MAX) begin
                        ages[IW*i +: IW] <= ages[IW*i +: IW] + 1'b1;
                     end
                  end
               end else begin
                  alloc_drop <= 1'b1;
               end
            end else begin
               for (int i = 0; i < NUM_VOICES; i++)
                  if (voice_gate[i] && voice_note[7*i +: 7] == data1)
                     voice_gate[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb/tb_midi_voice_allocator.sv - scoreboard bench with a message-level reference model; honours MIDI_VOICE_STEAL_EN
module tb_midi_voice_allocator;

   localparam int NV = 4;
   localparam int CH = 0;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [7:0]      byte_in = 8'h00;
   logic            byte_valid = 1'b0;
   logic            byte_rd;
   logic [NV-1:0]   voice_gate;
   logic [7*NV-1:0] voice_note;
   logic [7*NV-1:0] voice_vel;
   logic            alloc_drop;

   always #5 clk = ~clk;

   midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(CH)) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_rd    (byte_rd),
      .voice_gate (voice_gate),
      .voice_note (voice_note),
      .voice_vel  (voice_vel),
      .alloc_drop (alloc_drop)
   );

   typedef struct packed {
      logic [NV-1:0]   gate;
      logic [7*NV-1:0] note;
      logic [7*NV-1:0] vel;
      logic            drop;
   } snap_t;

   snap_t exp_q[$];
   snap_t last_exp = '0;
   int    passed = 0;
   int    total = 0;
   bit    mon_on = 1'b0;

   // Reference model: voices as plain arrays, ages derived from allocation timestamps
   bit m_gate[NV];
   int m_note[NV];
   int m_vel[NV];
   int m_stamp[NV];
   int alloc_cnt = 0;
   int run_stat = -1;
   int dq[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic snap_t model_snap(bit drop);
      snap_t s;
      s = '0;
      for (int i = 0; i < NV; i++) begin
         s.gate[i]        = m_gate[i];
         s.note[7*i +: 7] = m_note[i][6:0];
         s.vel[7*i +: 7]  = m_vel[i][6:0];
      end
      s.drop = drop;
      return s;
   endfunction

   function automatic void model_publish(bit drop);
      snap_t s;
      s = model_snap(drop);
      if (drop || s != last_exp) exp_q.push_back(s);
      s.drop = 1'b0;
      last_exp = s;
   endfunction

   function automatic int age_of(int i);
      int a;
      a = alloc_cnt - m_stamp[i];
      return (a > NV - 1) ? NV - 1 : a;
   endfunction

   function automatic void model_note(bit on, int d1, int d2);
      int t, best;
      t = -1;
      best = -1;
      if (on && d2 != 0) begin
         for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] && m_note[i] == d1) t = i;
         for (int i = 0; i < NV; i++) if (t < 0 && !m_gate[i]) t = i;
`ifdef MIDI_VOICE_STEAL_EN
         if (t < 0)
            for (int i = 0; i < NV; i++)
               if (age_of(i) > best) begin best = age_of(i); t = i; end
`endif
         if (t >= 0) begin
            alloc_cnt++;
            m_stamp[t] = alloc_cnt;
            m_gate[t]  = 1'b1;
            m_note[t]  = d1;
            m_vel[t]   = d2;
            model_publish(1'b0);
         end else begin
            model_publish(1'b1);
         end
      end else begin
         for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == d1) m_gate[i] = 1'b0;
         model_publish(1'b0);
      end
   endfunction

   function automatic void model_byte(int b);
      int d1, d2;
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin
         run_stat = -1;
         dq.delete();
      end else if (b >= 'h80) begin
         dq.delete();
         if ((b & 15) == CH && ((b >> 4) == 8 || (b >> 4) == 9)) run_stat = b;
         else run_stat = 'h100;
      end else if (run_stat >= 0) begin
         dq.push_back(b);
         if (dq.size() == 2) begin
            d1 = dq[0];
            d2 = dq[1];
            dq.delete();
            if (run_stat != 'h100) model_note((run_stat >> 4) == 9, d1, d2);
         end
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NV; i++) begin
         m_gate[i] = 1'b0;
         m_note[i] = 0;
         m_vel[i]  = 0;
      end
      run_stat = -1;
      dq.delete();
      model_publish(1'b0);
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.gate = voice_gate;
      s.note = voice_note;
      s.vel  = voice_vel;
      s.drop = alloc_drop;
      return s;
   endfunction

   // Callers are always positioned just after a falling edge
   task automatic send_byte(input logic [7:0] b);
      bit took;
      took = 1'b0;
      byte_in = b;
      byte_valid = 1'b1;
      for (int k = 0; k < 10 && !took; k++) begin
         #2;
         took = byte_rd;
         @(negedge clk);
      end
      check("byte_pop", took, 1);
      if (took) model_byte(b);
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[i]) send_byte(s[i]);
   endtask

   task automatic idle(input int n);
      byte_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      idle(1);
      reset = 1'b0;
      model_reset();
      byte_in = 8'h3C;
      byte_valid = 1'b1;
      #2;
      check("byte_rd_in_reset", byte_rd, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      byte_valid = 1'b0;
   endtask

   function automatic logic [7:0] gen_byte();
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) return 8'(8'h90 | CH);
      if (r < 16) return 8'(8'h80 | CH);
      if (r < 19) return 8'(8'h80 + $urandom_range(0, 8'h6F));
      if (r < 21) return 8'(8'hF0 + $urandom_range(0, 7));
      if (r < 25) return 8'(8'hF8 + $urandom_range(0, 7));
      if (r < 32) return 8'h00;
      return 8'(8'h3C + $urandom_range(0, 7));
   endfunction

   initial begin
      snap_t cur, prev, e;
      wait (mon_on);
      prev = dut_snap();
      forever begin
         @(negedge clk);
         cur = dut_snap();
         if (cur.gate != prev.gate || cur.note != prev.note || cur.vel != prev.vel || cur.drop) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_output: got %0h expected no change", cur);
            end else begin
               e = exp_q.pop_front();
               check("voice_snapshot", cur, e);
            end
         end
         prev = cur;
         prev.drop = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      exp_q.delete();
      byte_in = 8'h90;
      byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("reset_byte_rd", byte_rd, 0);
      check("reset_gate", voice_gate, 0);
      check("reset_note", voice_note, 0);
      check("reset_vel", voice_vel, 0);
      check("reset_drop", alloc_drop, 0);
      @(negedge clk);
      reset = 1'b1;
      byte_valid = 1'b0;
      mon_on = 1'b1;

      // Note On then Note Off, with ALLOC timing
      send_seq('{8'h90, 8'h3C, 8'h64});
      byte_valid = 1'b0;
      check("alloc_not_yet", voice_gate, 0);
      byte_in = 8'hF8;
      byte_valid = 1'b1;
      #2;
      check("byte_rd_in_alloc", byte_rd, 0);
      idle(1);
      check("on_gate0", voice_gate[0], 1);
      check("on_note0", voice_note[6:0], 7'h3C);
      check("on_vel0", voice_vel[6:0], 7'h64);
      send_seq('{8'h80, 8'h3C, 8'h00});
      idle(2);
      check("off_gate0", voice_gate, 0);
      check("off_note_kept", voice_note[6:0], 7'h3C);

      // Running status
      do_reset();
      send_seq('{8'h90, 8'h40, 8'h50, 8'h41, 8'h50});
      idle(2);
      check("rs_notes", voice_note[13:0], {7'h41, 7'h40});
      send_seq('{8'h40, 8'h00});
      idle(2);
      check("rs_off_gate", voice_gate, 4'b0010);

      // Realtime interleave and channel filter
      do_reset();
      send_seq('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64});
      idle(2);
      check("rt_voice0", {voice_gate[0], voice_note[6:0], voice_vel[6:0]}, {1'b1, 7'h3C, 7'h64});
      send_seq('{8'h91, 8'h3C, 8'h64});
      idle(2);
      check("chan_filter_gate", voice_gate, 4'b0001);

      // Five notes into four voices
      do_reset();
      send_seq('{8'h90, 8'h3C, 8'h40, 8'h3D, 8'h40, 8'h3E, 8'h40, 8'h3F, 8'h40, 8'h40, 8'h40});
      byte_valid = 1'b0;
      check("full_drop_in_alloc", alloc_drop, 0);
      @(negedge clk);
`ifdef MIDI_VOICE_STEAL_EN
      check("full_drop_steal", alloc_drop, 0);
      check("full_steal_v0", voice_note[6:0], 7'h40);
`else
      check("full_drop_pulse", alloc_drop, 1);
      check("full_keep_v0", voice_note[6:0], 7'h3C);
`endif
      @(negedge clk);
      check("full_drop_end", alloc_drop, 0);

      // Abort by status byte, then reset mid-message
      do_reset();
      send_seq('{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h80, 8'h3C, 8'h00});
      idle(2);
      check("abort_off", voice_gate, 0);
      do_reset();
      send_byte(8'h90);
      do_reset();
      send_seq('{8'h3C, 8'h64});
      idle(2);
      check("reset_mid_msg", voice_gate, 0);

      for (int n = 0; n < 1500; n++) begin
         int r;
         r = $urandom_range(0, 199);
         if (r < 3) do_reset();
         else if (r < 12) idle($urandom_range(1, 3));
         else send_byte(gen_byte());
      end

      idle(5);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
